// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with hold-until-release grants.
// Optional hold limit compiled in with `define RR_ARB_TIMEOUT_EN (MAX_HOLD cycles per grant).
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic StIdle  = 1'b0;
  localparam logic StGrant = 1'b1;

  // Reject out-of-range hold limits at elaboration.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : gen_max_hold_check
    $error("rr_arbiter8: MAX_HOLD must be in 2..255");
  end

  logic       state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic [2:0] scan_idx;
  logic       owner_req;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HoldLimit = 8'(MAX_HOLD - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       timeout_q, timeout_d;
`endif

  assign owner_req = req[gnt_idx_q];

  // Rotating-priority scan: first set request at or after ptr, wrapping mod 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    scan_idx  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      scan_idx = ptr_q + 3'(i);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Next-state: issue in IDLE, hold or release (or time out) in GRANT.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        if (enable && win_found) begin
          gnt_d       = 8'b1 << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          ptr_d       = win_idx + 3'd1;
          state_d     = StGrant;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = 8'd0;
`endif
        end
      end
      StGrant: begin
        // A release always wins over the hold limit on the same edge.
        if (!owner_req) begin
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          state_d     = StIdle;
`ifdef RR_ARB_TIMEOUT_EN
        end else if (hold_cnt_q == HoldLimit) begin
          gnt_d       = 8'd0;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = StIdle;
        end else if (hold_cnt_q != 8'hFF) begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 3'd0;
      gnt_q       <= 8'd0;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
    end
  end

`ifdef RR_ARB_TIMEOUT_EN
  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= 8'd0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Self-checking bench for rr_arbiter8: vector table, corner sequences, random vs reference model.
module tb_rr_arbiter8;

  localparam int unsigned MaxHold = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_cmp  = 0;
  int n_fail = 0;

  rr_arbiter8 #(.MAX_HOLD(MaxHold)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner (-1 = none), rotate pointer and hold length as plain integers.
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  bit m_tout  = 1'b0;
  int n_owner, n_ptr, n_hold;
  bit n_tout;

  function automatic int rr_pick(input logic [7:0] r, input int p);
    for (int k = 0; k < 8; k++) if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner <= -1;
      m_ptr   <= 0;
      m_hold  <= 0;
      m_tout  <= 1'b0;
    end else begin
      n_owner = m_owner;
      n_ptr   = m_ptr;
      n_hold  = m_hold;
      n_tout  = 1'b0;
      if (m_owner < 0) begin
        if (enable && rr_pick(req, m_ptr) >= 0) begin
          n_owner = rr_pick(req, m_ptr);
          n_ptr   = (n_owner + 1) % 8;
          n_hold  = 0;
        end
      end else if (!req[m_owner]) begin
        n_owner = -1;
      end else if (ToEn && m_hold == int'(MaxHold) - 1) begin
        n_owner = -1;
        n_tout  = 1'b1;
      end else if (m_hold < 255) begin
        n_hold = m_hold + 1;
      end
      m_owner <= n_owner;
      m_ptr   <= n_ptr;
      m_hold  <= n_hold;
      m_tout  <= n_tout;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string name);
    logic [7:0] eg;
    logic [2:0] ei;
    eg = (m_owner >= 0) ? (8'b1 << m_owner) : 8'h00;
    ei = (m_owner >= 0) ? 3'(m_owner) : 3'd0;
    check(name, {19'd0, gnt, gnt_idx, gnt_valid, timeout},
          {19'd0, eg, ei, (m_owner >= 0), m_tout});
  endtask

  // Drive inputs mid-cycle, let one rising edge pass, sample 1 ns later.
  task automatic tick(input logic [7:0] r, input logic e);
    @(negedge clk);
    req    = r;
    enable = e;
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req    = 8'h00;
    enable = 1'b0;
    #1;
    check("reset_state", {20'd0, gnt, gnt_idx, gnt_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0] r;
    logic       e;
    logic [7:0] g;
    logic [2:0] gi;
    logic       gv;
  } vec_t;

  vec_t vecs[20];

  initial begin
    // req, enable -> gnt, gnt_idx, gnt_valid after the edge
    vecs[0]  = '{8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
    vecs[1]  = '{8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
    vecs[2]  = '{8'h80, 1'b1, 8'h00, 3'd0, 1'b0};  // owner drops: bubble
    vecs[3]  = '{8'h80, 1'b1, 8'h80, 3'd7, 1'b1};
    vecs[4]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[5]  = '{8'h03, 1'b1, 8'h01, 3'd0, 1'b1};  // ptr wrapped to 0
    vecs[6]  = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};
    vecs[7]  = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0};  // disabled x5
    vecs[8]  = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[9]  = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[10] = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[11] = '{8'h10, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[12] = '{8'h10, 1'b1, 8'h10, 3'd4, 1'b1};
    vecs[13] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1};  // enable low mid-grant: held
    vecs[14] = '{8'h10, 1'b0, 8'h10, 3'd4, 1'b1};
    vecs[15] = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
    vecs[16] = '{8'h20, 1'b1, 8'h20, 3'd5, 1'b1};
    vecs[17] = '{8'h40, 1'b1, 8'h00, 3'd0, 1'b0};  // release + new request: release first
    vecs[18] = '{8'h40, 1'b1, 8'h40, 3'd6, 1'b1};
    vecs[19] = '{8'h00, 1'b1, 8'h00, 3'd0, 1'b0};

    do_reset();
    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].e);
      check($sformatf("vec%0d", i), {20'd0, gnt, gnt_idx, gnt_valid},
            {20'd0, vecs[i].g, vecs[i].gi, vecs[i].gv});
    end

    // Full rotation with 8'hFF: each owner drops for one cycle after its grant.
    do_reset();
    for (int k = 0; k < 9; k++) begin
      logic [7:0] oh;
      oh = 8'b1 << (k % 8);
      tick(8'hFF, 1'b1);
      check($sformatf("rot_grant%0d", k), {21'd0, gnt, gnt_idx}, {21'd0, oh, 3'(k % 8)});
      tick(8'hFF & ~oh, 1'b1);
      check($sformatf("rot_bubble%0d", k), {23'd0, gnt, gnt_valid}, 32'd0);
    end

    // Asynchronous reset mid-grant, then scan restarts from requester 0.
    do_reset();
    tick(8'h08, 1'b1);
    check("pre_rst_gnt", {24'd0, gnt}, 32'h08);
    #1;
    rst_n = 1'b0;
    req   = 8'h00;
    #1;
    check("async_rst", {19'd0, gnt, gnt_idx, gnt_valid, timeout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(8'h88, 1'b1);
    check("post_rst_scan", {21'd0, gnt, gnt_idx}, {21'd0, 8'h08, 3'd3});
    tick(8'h00, 1'b1);

    // Hold limit behaviour with req = 8'h03 held.
    do_reset();
    tick(8'h03, 1'b1);
    check("hold_first", {23'd0, gnt, timeout}, {23'd0, 8'h01, 1'b0});
`ifdef RR_ARB_TIMEOUT_EN
    for (int k = 1; k < int'(MaxHold); k++) begin
      tick(8'h03, 1'b1);
      check($sformatf("hold_cyc%0d", k), {23'd0, gnt, timeout}, {23'd0, 8'h01, 1'b0});
    end
    tick(8'h03, 1'b1);
    check("timeout_pulse", {23'd0, gnt, timeout}, {23'd0, 8'h00, 1'b1});
    tick(8'h03, 1'b1);
    check("after_timeout", {23'd0, gnt, timeout}, {23'd0, 8'h02, 1'b0});
`else
    for (int k = 1; k < 100; k++) begin
      tick(8'h03, 1'b1);
      check($sformatf("hold_cyc%0d", k), {23'd0, gnt, timeout}, {23'd0, 8'h01, 1'b0});
    end
`endif
    tick(8'h00, 1'b1);

    // Randomized traffic against the reference model; sticky requests give long holds.
    do_reset();
    begin
      logic [7:0] r;
      r = 8'h00;
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 9) < 3) r = 8'($urandom);
        tick(r, ($urandom_range(0, 9) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Eight-requester round-robin arbiter with hold-until-release handshake. It shares a single downstream resource (the 8-input encoder datapath and whatever consumes its index) among eight requesters. The search is a rotating-priority scan whose encoded output matches the encoder's 3-bit index plus valid convention. Grants are registered and held until the owner drops its request. An optional compile-time timeout caps hold length.

## Interface
- `MAX_HOLD`, default 16: maximum grant length in cycles when timeout is compiled in; legal range 2..255.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `enable` input 1: when low, no new grant is issued; an active grant continues.
- `req` input 8: request vector; bit 0 is requester a, bit 7 is requester h.
- `gnt` output 8: one-hot grant, registered; all zero when no owner.
- `gnt_idx` output 3: binary index of the owner, registered; 0 when `gnt_valid`=0.
- `gnt_valid` output 1: high while any grant is held.
- `timeout` output 1: one-cycle pulse when a grant is revoked by the hold limit; constant 0 when the timeout feature is not compiled in.

## Operation
- Two states, IDLE and GRANT; 3-bit rotate pointer `ptr`; 8-bit hold counter `hold_cnt`.
- IDLE, with `enable`=1 and `req`≠0:
  - Select the first set bit scanning `ptr`, `ptr`+1, … mod 8.
  - Load `gnt`/`gnt_idx`/`gnt_valid`.
  - Set `ptr` = winner+1 mod 8 (7 wraps to 0).
  - Clear `hold_cnt`; go to GRANT.
- IDLE, with `enable`=0 or `req`=0: outputs remain zero; `ptr` unchanged.
- GRANT, when `req[gnt_idx]`=0: clear outputs; go to IDLE.
- GRANT, while `req[gnt_idx]`=1: hold outputs; `hold_cnt` increments, saturating at 255.
- Requests from non-owners during GRANT are ignored. They are not latched; they must stay asserted to be seen.
- `enable` falling during GRANT has no effect on the current owner.
- `req` is sampled only at the clock edge. Glitches between edges are irrelevant. Inputs must be synchronous to `clk`.
- Reset, asynchronous, including mid-grant:
  - State → IDLE, `ptr`=0, `hold_cnt`=0.
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, all immediately.
  - The first post-reset arbitration scans from requester 0.

## Timing
- Grant latency: `req` sampled at edge N, with outputs valid after edge N (one cycle).
- Release latency: `req[owner]` low at edge N, outputs cleared after edge N.
- Mandatory one-cycle IDLE bubble between consecutive grants. Maximum grant rate is one per 2 cycles.
- Re-request by the released owner competes normally. Its priority is lowest because `ptr` has already advanced past it.
- A simultaneous release and new request in the same cycle is handled as release first. The new request is arbitrated on the following edge.
- `timeout` is asserted for exactly the cycle in which outputs clear due to the limit.

## Configuration
- Macro: `RR_ARB_TIMEOUT_EN`.
- Defined:
  - In GRANT, when `hold_cnt` = `MAX_HOLD`-1 and the owner still requests, the next edge clears the grant, pulses `timeout`, and goes to IDLE.
  - The owner's persisting request is treated like any other; rotation ensures others win first.
  - A release on the same edge as the limit counts as a normal release, with `timeout`=0.
- Undefined: no hold limit, `timeout` tied 0, and `hold_cnt` logic removed.

## Test plan
- Reset then `req`=8'h81, `enable`=1 → after 1 edge `gnt`=8'h01, `gnt_idx`=0; drop `req[0]` → IDLE bubble, then `gnt`=8'h80, `gnt_idx`=7, and `ptr` wraps to 0.
- `req`=8'hFF held continuously with each owner releasing for 1 cycle after grant → grant order 0,1,2,…,7,0 with exactly one idle cycle between grants.
- `enable`=0 with `req`=8'h10 → outputs stay 0 for 5 cycles; raise `enable` → `gnt`=8'h10 one cycle later; then lower `enable` mid-grant → grant held until `req[4]` drops.
- Assert `rst_n`=0 asynchronously mid-grant (`gnt`=8'h08) → all outputs 0 before the next clock edge; after release, `req`=8'h88 → `gnt`=8'h08 (scan from 0).
- With `RR_ARB_TIMEOUT_EN` and `MAX_HOLD`=4, `req`=8'h03 held → `gnt`=8'h01 for 4 cycles, `timeout` pulse, bubble, then `gnt`=8'h02; without the macro, `gnt`=8'h01 persists 100 cycles with `timeout`=0.
- Owner release coincident with a new request from another requester → new grant appears two edges later, never in the same cycle as the clear.
